gb_mem_arbiter: RTL and testbench

//  Shares the single external SDRAM port between the three memory clients of the GB core:
//  - cartridge ROM fetch (rom_*), fed from mbc_addr / rom_rd;
//  - cartridge RAM access (cram_*);
//  - backup/save transfer (bk_*).

---
 rtl/gb_mem_arb_pkg.sv | 35 +++
 rtl/gb_mem_arb_prio.sv | 61 ++++++
 rtl/gb_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_gb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_mem_arb_pkg.sv
// Shared state encodings, client ids and byte-lane helpers for the GB memory arbiter.
package gb_mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMD  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  typedef logic [1:0] client_t;

  localparam client_t CL_ROM  = 2'd0;
  localparam client_t CL_CRAM = 2'd1;
  localparam client_t CL_BK   = 2'd2;

  localparam logic [24:0] CRAM_BASE_DEF = 25'h0800000;

  // One fully-formed SDRAM command, latched when a client wins arbitration.
  typedef struct packed {
    logic [24:0] addr;
    logic [1:0]  be;
    logic [15:0] din;
    logic        we;
  } mem_cmd_t;

  function automatic logic [1:0] lane_be(input logic odd);
    return odd ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/gb_mem_arb_prio.sv
// Fixed-priority pick (rom > cram > bk) with a starvation counter that promotes bk.
module gb_mem_arb_prio
  import gb_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    rom_req_i,
  input  logic    cram_req_i,
  input  logic    bk_req_i,
  input  logic    grant_i,
  output client_t win_id_o,
  output logic    win_valid_o
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          bk_promote;

  assign bk_promote = bk_req_i && (starve_q == StarveMax);

  always_comb begin
    win_id_o    = CL_ROM;
    win_valid_o = 1'b1;
    if (bk_promote) begin
      win_id_o = CL_BK;
    end else if (rom_req_i) begin
      win_id_o = CL_ROM;
    end else if (cram_req_i) begin
      win_id_o = CL_CRAM;
    end else if (bk_req_i) begin
      win_id_o = CL_BK;
    end else begin
      win_valid_o = 1'b0;
    end
  end

  // Only arbitration rounds that actually grant count as a loss for bk.
  always_comb begin
    starve_d = starve_q;
    if (grant_i && bk_req_i) begin
      if (win_id_o == CL_BK) begin
        starve_d = '0;
      end else if (starve_q != StarveMax) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/gb_mem_arbiter.sv
// Shares one SDRAM port between ROM fetch, cart RAM and backup clients, one
// transaction at a time, with a registered one-cycle ack per client.
module gb_mem_arbiter
  import gb_mem_arb_pkg::*;
#(
  parameter logic [24:0] CRAM_BASE  = CRAM_BASE_DEF,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rom_req,
  input  logic [22:0] rom_addr,
  output logic        rom_ack,
  output logic [7:0]  rom_q,
  input  logic        cram_req,
  input  logic        cram_we,
  input  logic [16:0] cram_addr,
  input  logic [7:0]  cram_d,
  output logic        cram_ack,
  output logic [7:0]  cram_q,
  input  logic        bk_req,
  input  logic        bk_we,
  input  logic [16:0] bk_addr,
  input  logic [15:0] bk_d,
  output logic        bk_ack,
  output logic [15:0] bk_q,
  output logic [24:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_q,
  input  logic        mem_ready,
  output logic        err_tmo
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  client_t       id_q;
  client_t       win_id;
  logic          win_valid;
  logic          grant, done, tmo_hit;
  mem_cmd_t      cmd;
  logic [TW-1:0] tmo_q;
  logic [15:0]   rdata;

  gb_mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk_i      (clk),
    .rst_i      (reset),
    .rom_req_i  (rom_req),
    .cram_req_i (cram_req),
    .bk_req_i   (bk_req),
    .grant_i    (grant),
    .win_id_o   (win_id),
    .win_valid_o(win_valid)
  );

  assign grant   = (state_q == ST_IDLE) && win_valid;
  assign tmo_hit = (tmo_q == TmoLast);
  assign done    = (state_q == ST_WAIT) && (mem_ready || tmo_hit);
  // A forced completion returns all ones; a late mem_ready on the last cycle still wins.
  assign rdata   = mem_ready ? mem_q : 16'hFFFF;

  always_comb begin
    cmd = '0;
    case (win_id)
      CL_ROM: begin
        cmd.addr = {2'b00, rom_addr};
        cmd.be   = lane_be(rom_addr[0]);
        cmd.we   = 1'b0;
      end
      CL_CRAM: begin
        cmd.addr = CRAM_BASE + {8'b0, cram_addr};
        cmd.be   = lane_be(cram_addr[0]);
        cmd.din  = {cram_d, cram_d};
        cmd.we   = cram_we;
      end
      CL_BK: begin
        cmd.addr = CRAM_BASE + {7'b0, bk_addr, 1'b0};
        cmd.be   = 2'b11;
        cmd.din  = bk_d;
        cmd.we   = bk_we;
      end
      default: cmd = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_CMD;
      ST_CMD:  state_d = ST_WAIT;
      ST_WAIT: if (done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      id_q     <= CL_ROM;
      tmo_q    <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_be   <= '0;
      mem_din  <= '0;
      rom_ack  <= 1'b0;
      rom_q    <= '0;
      cram_ack <= 1'b0;
      cram_q   <= '0;
      bk_ack   <= 1'b0;
      bk_q     <= '0;
      err_tmo  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Strobes are set on the grant edge so they are high only during CMD.
      mem_rd  <= grant && !cmd.we;
      mem_wr  <= grant && cmd.we;
      if (grant) begin
        id_q     <= win_id;
        mem_addr <= cmd.addr;
        mem_be   <= cmd.be;
        mem_din  <= cmd.din;
      end
      tmo_q    <= ((state_q == ST_WAIT) && !done) ? tmo_q + 1'b1 : '0;
      rom_ack  <= done && (id_q == CL_ROM);
      cram_ack <= done && (id_q == CL_CRAM);
      bk_ack   <= done && (id_q == CL_BK);
      if (done) begin
        case (id_q)
          CL_ROM:  rom_q  <= lane_byte(rdata, mem_addr[0]);
          CL_CRAM: cram_q <= lane_byte(rdata, mem_addr[0]);
          CL_BK:   bk_q   <= rdata;
          default: ;
        endcase
        if (!mem_ready) err_tmo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gb_mem_arbiter.sv
// Scoreboard bench for gb_mem_arbiter: expected SDRAM commands and client data are
// queued as requests are raised and checked as the arbiter serves them.
module tb_gb_mem_arbiter;

  localparam int TMO = 255;
  localparam logic [24:0] CBASE = 25'h0800000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rom_req, cram_req, cram_we, bk_req, bk_we, mem_ready;
  logic [22:0] rom_addr;
  logic [16:0] cram_addr, bk_addr;
  logic [7:0]  cram_d, rom_q, cram_q;
  logic [15:0] bk_d, bk_q, mem_din, mem_q;
  logic        rom_ack, cram_ack, bk_ack, mem_rd, mem_wr, err_tmo;
  logic [24:0] mem_addr;
  logic [1:0]  mem_be;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          cl;
    logic [24:0] addr;
    logic [1:0]  be;
    logic        we;
    logic [15:0] din;
    logic [15:0] rdata;
    logic [15:0] q;
    bit          drop;
  } exp_t;

  exp_t sb[$];

  gb_mem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .rom_ack  (rom_ack),
    .rom_q    (rom_q),
    .cram_req (cram_req),
    .cram_we  (cram_we),
    .cram_addr(cram_addr),
    .cram_d   (cram_d),
    .cram_ack (cram_ack),
    .cram_q   (cram_q),
    .bk_req   (bk_req),
    .bk_we    (bk_we),
    .bk_addr  (bk_addr),
    .bk_d     (bk_d),
    .bk_ack   (bk_ack),
    .bk_q     (bk_q),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_be   (mem_be),
    .mem_din  (mem_din),
    .mem_q    (mem_q),
    .mem_ready(mem_ready),
    .err_tmo  (err_tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] acks();
    return {bk_ack, cram_ack, rom_ack};
  endfunction

  function automatic logic [80:0] all_outs();
    return {rom_ack, rom_q, cram_ack, cram_q, bk_ack, bk_q, mem_addr, mem_rd, mem_wr,
            mem_be, mem_din, err_tmo};
  endfunction

  task automatic push_rom(input logic [22:0] a, input logic [15:0] rd, input bit drop);
    exp_t e;
    e.cl = 0; e.addr = {2'b00, a}; e.be = a[0] ? 2'b10 : 2'b01; e.we = 1'b0; e.din = '0;
    e.rdata = rd; e.q = a[0] ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]}; e.drop = drop;
    sb.push_back(e);
  endtask

  task automatic push_cram(input logic [16:0] a, input logic we, input logic [7:0] d,
                           input logic [15:0] rd, input bit drop);
    exp_t e;
    e.cl = 1; e.addr = CBASE + {8'b0, a}; e.be = a[0] ? 2'b10 : 2'b01; e.we = we;
    e.din = {d, d}; e.rdata = rd; e.q = a[0] ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]};
    e.drop = drop;
    sb.push_back(e);
  endtask

  task automatic push_bk(input logic [16:0] a, input logic we, input logic [15:0] d,
                         input logic [15:0] rd, input bit drop);
    exp_t e;
    e.cl = 2; e.addr = CBASE + {7'b0, a, 1'b0}; e.be = 2'b11; e.we = we; e.din = d;
    e.rdata = rd; e.q = rd; e.drop = drop;
    sb.push_back(e);
  endtask

  // Serves the oldest queued transaction; delay < 0 means mem_ready is never given.
  task automatic run_txn(input int delay, output int lat);
    exp_t e;
    int k;
    logic [2:0] exp_ack;
    logic [15:0] got_q;
    lat = -1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_empty: no expected transaction queued");
      return;
    end
    e = sb.pop_front();
    exp_ack = 3'b001 << e.cl;
    k = 0;
    while (!(mem_rd || mem_wr) && k < 20) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    n_chk++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL strobe_wait client %0d: no strobe after %0d cycles, required within 20",
               e.cl, k);
      return;
    end
    n_chk++;
    if ({mem_addr, mem_be, mem_wr, mem_rd} !== {e.addr, e.be, e.we, !e.we}) begin
      n_fail++;
      $display("FAIL cmd client %0d: addr=%h be=%b wr=%b rd=%b, required addr=%h be=%b we=%b",
               e.cl, mem_addr, mem_be, mem_wr, mem_rd, e.addr, e.be, e.we);
    end
    if (e.we) begin
      n_chk++;
      if (mem_din !== e.din) begin
        n_fail++;
        $display("FAIL din client %0d: got %h, required %h", e.cl, mem_din, e.din);
      end
    end
    @(negedge clk);
    n_chk++;
    if ({mem_rd, mem_wr} !== 2'b00) begin
      n_fail++;
      $display("FAIL strobe_width client %0d: rd/wr=%b one cycle after strobe, required 00",
               e.cl, {mem_rd, mem_wr});
    end
    if (delay < 0) begin
      k = 1;
      while (acks() == 3'b000 && k < 400) begin
        @(negedge clk);
        k++;
      end
      n_chk++;
      if (k != TMO + 1) begin
        n_fail++;
        $display("FAIL tmo_latency client %0d: ack %0d cycles after CMD, required %0d",
                 e.cl, k, TMO + 1);
      end
    end else begin
      repeat (delay - 1) @(negedge clk);
      n_chk++;
      if (acks() !== 3'b000) begin
        n_fail++;
        $display("FAIL early_ack client %0d: acks=%b before mem_ready, required 000",
                 e.cl, acks());
      end
      mem_ready = 1'b1;
      mem_q = e.rdata;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    n_chk++;
    if (acks() !== exp_ack) begin
      n_fail++;
      $display("FAIL ack client %0d: acks=%b, required %b", e.cl, acks(), exp_ack);
    end
    got_q = (e.cl == 0) ? {8'h00, rom_q} : (e.cl == 1) ? {8'h00, cram_q} : bk_q;
    n_chk++;
    if (got_q !== e.q) begin
      n_fail++;
      $display("FAIL q client %0d: got %h, required %h", e.cl, got_q, e.q);
    end
    if (e.drop) begin
      case (e.cl)
        0: rom_req = 1'b0;
        1: cram_req = 1'b0;
        default: bk_req = 1'b0;
      endcase
    end
    @(negedge clk);
    n_chk++;
    if (acks() !== 3'b000) begin
      n_fail++;
      $display("FAIL ack_width client %0d: acks=%b a cycle after ack, required 000",
               e.cl, acks());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_chk++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: outputs=%h, required all zero", all_outs());
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL idle_outs: outputs=%h after release, required all zero", all_outs());
    end
  endtask

  task automatic test_rom_read();
    int lat;
    rom_addr = 23'h000151;
    rom_req = 1'b1;
    push_rom(23'h000151, 16'hAB00, 1'b1);
    run_txn(4, lat);
    n_chk++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL rom_latency: strobe %0d cycles after req, required 1", lat);
    end
  endtask

  task automatic test_cram();
    int lat;
    cram_addr = 17'h00010; cram_d = 8'h5A; cram_we = 1'b1; cram_req = 1'b1;
    push_cram(17'h00010, 1'b1, 8'h5A, 16'h0000, 1'b1);
    run_txn(2, lat);
    cram_addr = 17'h00011; cram_we = 1'b0; cram_req = 1'b1;
    push_cram(17'h00011, 1'b0, 8'h00, 16'hC33C, 1'b1);
    run_txn(1, lat);
  endtask

  task automatic test_bk();
    int lat;
    bk_addr = 17'h1ABCD; bk_d = 16'h1234; bk_we = 1'b1; bk_req = 1'b1;
    push_bk(17'h1ABCD, 1'b1, 16'h1234, 16'h0000, 1'b1);
    run_txn(3, lat);
    bk_addr = 17'h00007; bk_we = 1'b0; bk_req = 1'b1;
    push_bk(17'h00007, 1'b0, 16'h0000, 16'hBEEF, 1'b1);
    run_txn(2, lat);
  endtask

  task automatic test_all_three();
    int lat;
    rom_addr = 23'h000AA0; rom_req = 1'b1;
    cram_addr = 17'h00100; cram_we = 1'b0; cram_req = 1'b1;
    bk_addr = 17'h00040; bk_we = 1'b0; bk_req = 1'b1;
    push_rom(23'h000AA0, 16'h1122, 1'b1);
    push_cram(17'h00100, 1'b0, 8'h00, 16'h3344, 1'b1);
    push_bk(17'h00040, 1'b0, 16'h0000, 16'h5566, 1'b1);
    for (int i = 0; i < 3; i++) run_txn(2, lat);
  endtask

  task automatic test_starvation();
    int lat;
    rom_addr = 23'h000003; rom_req = 1'b1;
    bk_addr = 17'h00123; bk_we = 1'b0; bk_req = 1'b1;
    for (int i = 0; i < 8; i++) push_rom(23'h000003, 16'h9000 + 16'(i), 1'b0);
    push_bk(17'h00123, 1'b0, 16'h0000, 16'hD00D, 1'b1);
    push_rom(23'h000003, 16'h4321, 1'b1);
    for (int i = 0; i < 10; i++) run_txn(1, lat);
  endtask

  task automatic test_timeout();
    int lat;
    rom_addr = 23'h000020; rom_req = 1'b1;
    push_rom(23'h000020, 16'hFFFF, 1'b1);
    run_txn(-1, lat);
    n_chk++;
    if (err_tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL err_tmo_set: got %b, required 1", err_tmo);
    end
    bk_addr = 17'h00055; bk_we = 1'b0; bk_req = 1'b1;
    push_bk(17'h00055, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
    run_txn(-1, lat);
    cram_addr = 17'h00002; cram_we = 1'b0; cram_req = 1'b1;
    push_cram(17'h00002, 1'b0, 8'h00, 16'h0077, 1'b1);
    run_txn(2, lat);
    n_chk++;
    if (err_tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL err_tmo_sticky: got %b after a normal access, required 1", err_tmo);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int lat;
    rom_addr = 23'h000200; rom_req = 1'b1;
    k = 0;
    while (!mem_rd && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL mid_strobe: no strobe after %0d cycles, required within 20", k);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: outputs=%h, required all zero", all_outs());
    end
    rom_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_q = 16'h1357;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({acks(), mem_rd, mem_wr} !== 5'b0) begin
      n_fail++;
      $display("FAIL stray_ready: acks/rd/wr=%b after reset, required 00000",
               {acks(), mem_rd, mem_wr});
    end
    rom_addr = 23'h000203; rom_req = 1'b1;
    push_rom(23'h000203, 16'h7788, 1'b1);
    run_txn(2, lat);
  endtask

  initial begin
    reset = 1'b1;
    rom_req = 1'b0; cram_req = 1'b0; bk_req = 1'b0;
    cram_we = 1'b0; bk_we = 1'b0; mem_ready = 1'b0;
    rom_addr = '0; cram_addr = '0; bk_addr = '0;
    cram_d = '0; bk_d = '0; mem_q = '0;
    test_reset();
    test_rom_read();
    test_cram();
    test_bk();
    test_all_three();
    test_starvation();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
